// File: rtl/tx_link_pkg.sv
// Shared types and constants for the transmit link-layer scheduler.
// The CRC-8 step function is used only when TX_LINK_CRC8_EN is defined.
package tx_link_pkg;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_SOF   = 8'hFB;
  localparam logic [7:0] K_EOF   = 8'hFD;
  localparam logic [7:0] K_FILL  = 8'h1C;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    ALIGN,
    IDLE,
    SOF,
    DATA,
    CRC,
    EOF
  } state_t;

  function automatic logic [7:0] crc8_byte(
    input logic [7:0] crc,
    input logic [7:0] data
  );
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY)
               : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/tx_crc8.sv
// Byte-wide CRC-8 accumulator (poly 0x07, init 0, MSB first).
// Built into tx_link_ctrl only when TX_LINK_CRC8_EN is defined.
module tx_crc8
  import tx_link_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_byte(crc, data);
    end
  end

endmodule

// File: rtl/tx_link_ctrl.sv
// Transmit link scheduler: comma burst, round-robin framing of two sources.
// Define TX_LINK_CRC8_EN to append a CRC-8 byte before each EOF.
module tx_link_ctrl
  import tx_link_pkg::*;
#(
  parameter int ALIGN_LEN = 64,
  parameter int MAX_LEN   = 256,
  parameter int GAP_LEN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       link_up,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] tx_data,
  output logic       tx_k,
  output logic       aligned,
  output logic       grant,
  output logic       busy,
  output logic       trunc
);

  localparam int AW = $clog2(ALIGN_LEN + 1);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int GW = $clog2(GAP_LEN + 1);

  localparam logic [AW-1:0] ALIGN_END = AW'(ALIGN_LEN - 1);
  localparam logic [LW-1:0] LEN_END   = LW'(MAX_LEN - 1);
  localparam logic [GW-1:0] GAP_END   = GW'(GAP_LEN);

  state_t          state;
  logic [AW-1:0]   align_cnt;
  logic [LW-1:0]   len_cnt;
  logic [GW-1:0]   gap_cnt;

  logic            hs;
  logic [7:0]      sel_data;
  logic            sel_last;
  logic            pick;
  logic            len_hit;

  assign s0_ready = (state == DATA) & ~grant & link_up;
  assign s1_ready = (state == DATA) &  grant & link_up;

  assign hs       = grant ? (s1_valid & s1_ready)
                          : (s0_valid & s0_ready);
  assign sel_data = grant ? s1_data : s0_data;
  assign sel_last = grant ? s1_last : s0_last;
  assign len_hit  = (len_cnt == LEN_END);

  // On a tie the source that did not own the last frame wins.
  assign pick = (s0_valid & s1_valid) ? ~grant : s1_valid;

`ifdef TX_LINK_CRC8_EN
  logic [7:0] crc;

  tx_crc8 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (state == SOF),
    .en    (hs),
    .data  (sel_data),
    .crc   (crc)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ALIGN;
      align_cnt <= '0;
      len_cnt   <= '0;
      gap_cnt   <= '0;
      tx_data   <= K_COMMA;
      tx_k      <= 1'b1;
      aligned   <= 1'b0;
      grant     <= 1'b0;
      busy      <= 1'b0;
      trunc     <= 1'b0;
    end else begin
      trunc <= 1'b0;
      if (!link_up) begin
        // Lost lock: abandon any frame, no EOF.
        state     <= ALIGN;
        align_cnt <= '0;
        aligned   <= 1'b0;
        busy      <= 1'b0;
        tx_data   <= K_COMMA;
        tx_k      <= 1'b1;
      end else begin
        unique case (state)
          ALIGN: begin
            tx_data <= K_COMMA;
            tx_k    <= 1'b1;
            if (align_cnt == ALIGN_END) begin
              state   <= IDLE;
              aligned <= 1'b1;
              gap_cnt <= '0;
            end else begin
              align_cnt <= align_cnt + 1'b1;
            end
          end
          IDLE: begin
            tx_data <= K_COMMA;
            tx_k    <= 1'b1;
            if (gap_cnt < GAP_END) begin
              gap_cnt <= gap_cnt + 1'b1;
            end
            if (gap_cnt >= GAP_END && (s0_valid || s1_valid)) begin
              grant <= pick;
              busy  <= 1'b1;
              state <= SOF;
            end
          end
          SOF: begin
            tx_data <= K_SOF;
            tx_k    <= 1'b1;
            len_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (hs) begin
              tx_data <= sel_data;
              tx_k    <= 1'b0;
              len_cnt <= len_cnt + 1'b1;
              if (sel_last || len_hit) begin
                trunc <= ~sel_last;
`ifdef TX_LINK_CRC8_EN
                state <= CRC;
`else
                state <= EOF;
`endif
              end
            end else begin
              tx_data <= K_FILL;
              tx_k    <= 1'b1;
            end
          end
`ifdef TX_LINK_CRC8_EN
          CRC: begin
            tx_data <= crc;
            tx_k    <= 1'b0;
            state   <= EOF;
          end
`endif
          EOF: begin
            tx_data <= K_EOF;
            tx_k    <= 1'b1;
            busy    <= 1'b0;
            gap_cnt <= '0;
            state   <= IDLE;
          end
          default: begin
            state <= ALIGN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Directed bench for tx_link_ctrl: alignment, framing, arbitration,
// truncation, link loss and (with TX_LINK_CRC8_EN) the CRC byte.
module tb_tx_link_ctrl;

  localparam logic [8:0] W_BC = 9'h1BC;
  localparam logic [8:0] W_FB = 9'h1FB;
  localparam logic [8:0] W_FD = 9'h1FD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       link_up = 1'b1;
  logic       s0_valid = 1'b0;
  logic [7:0] s0_data = 8'h00;
  logic       s0_last = 1'b0;
  logic       s0_ready;
  logic       s1_valid = 1'b0;
  logic [7:0] s1_data = 8'h00;
  logic       s1_last = 1'b0;
  logic       s1_ready;
  logic [7:0] tx_data;
  logic       tx_k;
  logic       aligned;
  logic       grant;
  logic       busy;
  logic       trunc;

  always #5 clk = ~clk;

  tx_link_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .link_up  (link_up),
    .s0_valid (s0_valid),
    .s0_data  (s0_data),
    .s0_last  (s0_last),
    .s0_ready (s0_ready),
    .s1_valid (s1_valid),
    .s1_data  (s1_data),
    .s1_last  (s1_last),
    .s1_ready (s1_ready),
    .tx_data  (tx_data),
    .tx_k     (tx_k),
    .aligned  (aligned),
    .grant    (grant),
    .busy     (busy),
    .trunc    (trunc)
  );

  int tests = 0;
  int fails = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] lw[$];
  logic       lg[$];
  logic       lt[$];
  logic       lb[$];
  int         rc0;
  int         rc1;

`ifdef TX_LINK_CRC8_EN
  function automatic logic [7:0] crc8_ref(logic [7:0] c, logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int b = 0; b < 8; b++) begin
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
    end
    return x;
  endfunction
`endif

  task automatic clear_log();
    lw.delete();
    lg.delete();
    lt.delete();
    lb.delete();
    rc0 = 0;
    rc1 = 0;
  endtask

  function automatic int find_w(int from, logic [8:0] w);
    for (int i = from; i < lw.size(); i++) begin
      if (lw[i] == w) return i;
    end
    return -1;
  endfunction

  // One clock: drive sources from queues, pop on handshake, log outputs.
  task automatic tick();
    bit r0;
    bit r1;
    if (q0.size() > 0) begin
      s0_valid = 1'b1;
      s0_data  = q0[0][7:0];
      s0_last  = q0[0][8];
    end else begin
      s0_valid = 1'b0;
      s0_data  = 8'h00;
      s0_last  = 1'b0;
    end
    if (q1.size() > 0) begin
      s1_valid = 1'b1;
      s1_data  = q1[0][7:0];
      s1_last  = q1[0][8];
    end else begin
      s1_valid = 1'b0;
      s1_data  = 8'h00;
      s1_last  = 1'b0;
    end
    #1;
    r0 = s0_ready;
    r1 = s1_ready;
    if (r0) rc0++;
    if (r1) rc1++;
    @(posedge clk);
    if (r0 && s0_valid) q0.delete(0);
    if (r1 && s1_valid) q1.delete(0);
    @(negedge clk);
    lw.push_back({tx_k, tx_data});
    lg.push_back(grant);
    lt.push_back(trunc);
    lb.push_back(busy);
  endtask

  task automatic test_reset();
    int n;
    int bad;
    rst = 1'b1;
    link_up = 1'b1;
    repeat (3) tick();
    tests++;
    if ({tx_k, tx_data} !== W_BC) begin
      fails++;
      $display("FAIL reset_word: got %h expected %h", {tx_k, tx_data}, W_BC);
    end
    tests++;
    if ({aligned, busy, grant, trunc} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0000",
               {aligned, busy, grant, trunc});
    end
    tests++;
    if ({s0_ready, s1_ready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 00", {s0_ready, s1_ready});
    end
    rst = 1'b0;
    clear_log();
    n = 0;
    while (!aligned && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 64) begin
      fails++;
      $display("FAIL align_len: got %0d expected 64", n);
    end
    bad = 0;
    foreach (lw[i]) if (lw[i] !== W_BC) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL align_words: got %0d non-BC expected 0", bad);
    end
    clear_log();
    repeat (2) tick();
    tests++;
    if ({lw[0], lw[1], aligned, busy} !== {W_BC, W_BC, 2'b10}) begin
      fails++;
      $display("FAIL idle_words: got %h %h a=%b b=%b expected 1bc 1bc a=1 b=0",
               lw[0], lw[1], aligned, busy);
    end
  endtask

  task automatic test_frame3();
    int fb;
    int fd;
    logic [8:0] ex[$];
    clear_log();
    q0.push_back(9'h011);
    q0.push_back(9'h022);
    q0.push_back(9'h133);
    repeat (14) tick();
    ex = '{9'h011, 9'h022, 9'h033};
`ifdef TX_LINK_CRC8_EN
    ex.push_back({1'b0, crc8_ref(crc8_ref(crc8_ref(8'h00, 8'h11), 8'h22), 8'h33)});
`endif
    fb = find_w(0, W_FB);
    tests++;
    if (fb !== 1) begin
      fails++;
      $display("FAIL f3_sof_pos: got %0d expected 1", fb);
      return;
    end
    foreach (ex[i]) begin
      tests++;
      if (lw[fb + 1 + i] !== ex[i]) begin
        fails++;
        $display("FAIL f3_word%0d: got %h expected %h", i, lw[fb + 1 + i], ex[i]);
      end
    end
    fd = fb + 1 + ex.size();
    tests++;
    if (lw[fd] !== W_FD) begin
      fails++;
      $display("FAIL f3_eof: got %h expected %h", lw[fd], W_FD);
    end
    tests++;
    if ({rc0, rc1} !== {32'd3, 32'd0}) begin
      fails++;
      $display("FAIL f3_ready_cycles: got %0d/%0d expected 3/0", rc0, rc1);
    end
    tests++;
    if ({lb[fb], lb[fd], lg[fb]} !== 3'b100) begin
      fails++;
      $display("FAIL f3_busy_grant: got %b expected 100", {lb[fb], lb[fd], lg[fb]});
    end
  endtask

  task automatic test_alternate();
    int pos;
    int fb;
    int fd;
    int prev_fd;
    logic eg;
    logic [7:0] ed;
    int bad;
    clear_log();
    for (int i = 0; i < 4; i++) begin
      q0.push_back({1'b1, 8'hA0 + 8'(i)});
      q1.push_back({1'b1, 8'hB0 + 8'(i)});
    end
    repeat (80) tick();
    pos = 0;
    prev_fd = -1;
    for (int k = 0; k < 8; k++) begin
      fb = find_w(pos, W_FB);
      tests++;
      if (fb < 0) begin
        fails++;
        $display("FAIL alt_sof%0d: got none expected FB", k);
        break;
      end
      eg = (k % 2 == 0);
      ed = (eg ? 8'hB0 : 8'hA0) + 8'(k / 2);
      if ({lg[fb], lw[fb + 1]} !== {eg, 1'b0, ed}) begin
        fails++;
        $display("FAIL alt_frame%0d: got g=%b %h expected g=%b %h",
                 k, lg[fb], lw[fb + 1], eg, {1'b0, ed});
      end
      if (prev_fd >= 0) begin
        bad = 0;
        for (int j = prev_fd + 1; j < fb; j++) if (lw[j] !== W_BC) bad++;
        tests++;
        if (fb - prev_fd - 1 < 2 || bad != 0) begin
          fails++;
          $display("FAIL alt_gap%0d: got %0d words (%0d non-BC) expected >=2 BC",
                   k, fb - prev_fd - 1, bad);
        end
      end
      fd = find_w(fb, W_FD);
      prev_fd = fd;
      pos = (fd < 0) ? fb + 1 : fd;
    end
    tests++;
    if (q0.size() + q1.size() !== 0) begin
      fails++;
      $display("FAIL alt_drain: got %0d left expected 0", q0.size() + q1.size());
    end
  endtask

  task automatic test_trunc();
    int f1;
    int c;
    int f2;
    int bad;
    int nt;
    logic [7:0] crc;
    clear_log();
    for (int i = 1; i <= 300; i++) q0.push_back({i == 300, 8'(i)});
    repeat (340) tick();
    f1 = find_w(0, W_FB);
    tests++;
    if (f1 < 0) begin
      fails++;
      $display("FAIL tr_sof1: got none expected FB");
      return;
    end
    bad = 0;
    crc = 8'h00;
    for (int i = 1; i <= 256; i++) begin
      if (lw[f1 + i] !== {1'b0, 8'(i)}) bad++;
`ifdef TX_LINK_CRC8_EN
      crc = crc8_ref(crc, 8'(i));
`endif
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL tr_payload1: got %0d bad bytes expected 0", bad);
    end
    c = f1 + 257;
`ifdef TX_LINK_CRC8_EN
    tests++;
    if (lw[c] !== {1'b0, crc}) begin
      fails++;
      $display("FAIL tr_crc1: got %h expected %h", lw[c], {1'b0, crc});
    end
    c++;
`endif
    tests++;
    if ({lw[c], lb[f1 + 256], lb[c]} !== {W_FD, 2'b10}) begin
      fails++;
      $display("FAIL tr_eof1: got %h busy %b%b expected %h busy 10",
               lw[c], lb[f1 + 256], lb[c], W_FD);
    end
    nt = 0;
    foreach (lt[i]) if (lt[i]) nt++;
    tests++;
    if (nt !== 1 || lt[f1 + 256] !== 1'b1) begin
      fails++;
      $display("FAIL tr_pulse: got %0d pulses at-256=%b expected 1 at-256=1",
               nt, lt[f1 + 256]);
    end
    f2 = find_w(c, W_FB);
    tests++;
    if (f2 - c - 1 < 2) begin
      fails++;
      $display("FAIL tr_sof2: got gap %0d expected >=2", f2 - c - 1);
      return;
    end
    bad = 0;
    crc = 8'h00;
    for (int j = 1; j <= 44; j++) begin
      if (lw[f2 + j] !== {1'b0, 8'(256 + j)}) bad++;
`ifdef TX_LINK_CRC8_EN
      crc = crc8_ref(crc, 8'(256 + j));
`endif
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL tr_payload2: got %0d bad bytes expected 0", bad);
    end
    c = f2 + 45;
`ifdef TX_LINK_CRC8_EN
    tests++;
    if (lw[c] !== {1'b0, crc}) begin
      fails++;
      $display("FAIL tr_crc2: got %h expected %h", lw[c], {1'b0, crc});
    end
    c++;
`endif
    tests++;
    if (lw[c] !== W_FD) begin
      fails++;
      $display("FAIL tr_eof2: got %h expected %h", lw[c], W_FD);
    end
  endtask

  task automatic test_linkdrop();
    int n;
    int fb;
    int st;
    int bad;
    logic [7:0] crc;
    clear_log();
    for (int i = 1; i <= 10; i++) q1.push_back({i == 10, 8'h40 + 8'(i)});
    n = 0;
    while (find_w(0, W_FB) < 0 && n < 20) begin
      tick();
      n++;
    end
    fb = find_w(0, W_FB);
    repeat (3) tick();
    tests++;
    if (lw[lw.size() - 1] !== 9'h043) begin
      fails++;
      $display("FAIL ld_pre: got %h expected 043", lw[lw.size() - 1]);
    end
    link_up = 1'b0;
    tick();
    tests++;
    if ({tx_k, tx_data, aligned, busy, s0_ready, s1_ready, grant}
        !== {W_BC, 5'b00001}) begin
      fails++;
      $display("FAIL ld_drop: got %h a%b b%b r%b%b g%b expected 1bc a0 b0 r00 g1",
               {tx_k, tx_data}, aligned, busy, s0_ready, s1_ready, grant);
    end
    tests++;
    if (q1.size() !== 7) begin
      fails++;
      $display("FAIL ld_left: got %0d expected 7", q1.size());
    end
    repeat (4) tick();
    tests++;
    if (fb < 0 || find_w(fb, W_FD) >= 0) begin
      fails++;
      $display("FAIL ld_no_eof: got fb=%0d fd=%0d expected no FD",
               fb, find_w(fb < 0 ? 0 : fb, W_FD));
    end
    link_up = 1'b1;
    st = lw.size();
    n = 0;
    while (!aligned && n < 200) begin
      tick();
      n++;
    end
    bad = 0;
    for (int i = st; i < lw.size(); i++) if (lw[i] !== W_BC) bad++;
    tests++;
    if (n !== 64 || bad !== 0) begin
      fails++;
      $display("FAIL ld_realign: got %0d cycles %0d non-BC expected 64 0", n, bad);
    end
    st = lw.size();
    repeat (24) tick();
    fb = find_w(st, W_FB);
    tests++;
    if (fb < 0) begin
      fails++;
      $display("FAIL ld_sof: got none expected FB");
      return;
    end
    bad = 0;
    crc = 8'h00;
    for (int j = 0; j < 7; j++) begin
      if (lw[fb + 1 + j] !== {1'b0, 8'h44 + 8'(j)}) bad++;
`ifdef TX_LINK_CRC8_EN
      crc = crc8_ref(crc, 8'h44 + 8'(j));
`endif
    end
`ifdef TX_LINK_CRC8_EN
    if (lw[fb + 8] !== {1'b0, crc}) bad++;
    if (lw[fb + 9] !== W_FD) bad++;
`else
    if (lw[fb + 8] !== W_FD) bad++;
`endif
    tests++;
    if (bad !== 0 || lg[fb] !== 1'b1) begin
      fails++;
      $display("FAIL ld_resume: got %0d bad words g=%b expected 0 g=1", bad, lg[fb]);
    end
  endtask

`ifdef TX_LINK_CRC8_EN
  task automatic test_crc();
    int fb;
    clear_log();
    q0.push_back(9'h101);
    repeat (12) tick();
    fb = find_w(0, W_FB);
    tests++;
    if (fb < 0 || {lw[fb + 1], lw[fb + 2], lw[fb + 3]} !== {9'h001, 9'h007, W_FD}) begin
      fails++;
      $display("FAIL crc_01: got %h %h %h expected 001 007 1fd",
               lw[fb + 1], lw[fb + 2], lw[fb + 3]);
    end
    clear_log();
    q0.push_back(9'h100);
    repeat (12) tick();
    fb = find_w(0, W_FB);
    tests++;
    if (fb < 0 || {lw[fb + 1], lw[fb + 2], lw[fb + 3]} !== {9'h000, 9'h000, W_FD}) begin
      fails++;
      $display("FAIL crc_00: got %h %h %h expected 000 000 1fd",
               lw[fb + 1], lw[fb + 2], lw[fb + 3]);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_frame3();
    test_alternate();
    test_trunc();
    test_linkdrop();
`ifdef TX_LINK_CRC8_EN
    test_crc();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
